// File: rtl/sort_floats_serial.sv
// Serial three-word float sorter: loads a triple, bubble-sorts it with one shared
// comparator over three cycles, then streams the words out in ascending order.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal (
   input  logic [`FLEN-1:0] a,
   input  logic [`FLEN-1:0] b,
   output logic             res,
   output logic             err
);
   localparam int FLEN = `FLEN;
   localparam int EW   = (FLEN == 64) ? 11 : ((FLEN == 32) ? 8 : 5);
   localparam int MW   = FLEN - 1 - EW;

   logic a_nan, b_nan, both_zero;

   assign a_nan     = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
   assign b_nan     = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
   assign both_zero = (a[FLEN-2:0] == '0) && (b[FLEN-2:0] == '0);
   assign err       = a_nan | b_nan;

   // Sign-magnitude order; +0 and -0 compare equal.
   always_comb begin
      res = 1'b0;
      if (err)                     res = 1'b0;
      else if (both_zero)          res = 1'b1;
      else if (a[FLEN-1] != b[FLEN-1]) res = a[FLEN-1];
      else if (!a[FLEN-1])         res = (a[FLEN-2:0] <= b[FLEN-2:0]);
      else                         res = (a[FLEN-2:0] >= b[FLEN-2:0]);
   end
endmodule

module sort_floats_serial (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [`FLEN-1:0] up_data,
   output logic             up_ready,
   output logic             down_valid,
   output logic [`FLEN-1:0] down_data,
   output logic             down_last,
   output logic             down_err,
   input  logic             down_ready
);
   localparam int FLEN = `FLEN;

   typedef enum logic [2:0] {S_LOAD, S_C01A, S_C12, S_C01B, S_OUT} state_t;

   state_t          state_q;
   logic [1:0]      cnt_q, idx_q;
   logic            err_q;
   logic [FLEN-1:0] buf_q [3];
   logic            up_ready_q, down_valid_q, down_last_q, down_err_q;
   logic [FLEN-1:0] down_data_q;

   logic [FLEN-1:0] cmp_a, cmp_b;
   logic            cmp_res, cmp_err, swap;

   always_comb begin
      cmp_a = buf_q[0];
      cmp_b = buf_q[1];
      if (state_q == S_C12) begin
         cmp_a = buf_q[1];
         cmp_b = buf_q[2];
      end
   end

   f_less_or_equal u_cmp (.a(cmp_a), .b(cmp_b), .res(cmp_res), .err(cmp_err));

   // Equal or unordered pairs stay put, which keeps the sort stable.
   assign swap = !cmp_res && !cmp_err;

   always_ff @(posedge clk) begin
      case (state_q)
         S_LOAD: if (up_valid && up_ready_q) buf_q[cnt_q] <= up_data;
         S_C01A, S_C01B: if (swap) begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= buf_q[0];
         end
         S_C12: if (swap) begin
            buf_q[1] <= buf_q[2];
            buf_q[2] <= buf_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_LOAD;
         cnt_q        <= 2'd0;
         idx_q        <= 2'd0;
         err_q        <= 1'b0;
         up_ready_q   <= 1'b1;
         down_valid_q <= 1'b0;
         down_last_q  <= 1'b0;
         down_err_q   <= 1'b0;
         down_data_q  <= '0;
      end else begin
         case (state_q)
            S_LOAD: if (up_valid && up_ready_q) begin
               if (cnt_q == 2'd2) begin
                  cnt_q      <= 2'd0;
                  up_ready_q <= 1'b0;
                  state_q    <= S_C01A;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            S_C01A: begin
               err_q   <= err_q | cmp_err;
               state_q <= S_C12;
            end
            S_C12: begin
               err_q   <= err_q | cmp_err;
               state_q <= S_C01B;
            end
            // Preload the first output word from the post-swap pair.
            S_C01B: begin
               err_q        <= err_q | cmp_err;
               down_err_q   <= err_q | cmp_err;
               down_data_q  <= swap ? buf_q[1] : buf_q[0];
               down_last_q  <= 1'b0;
               down_valid_q <= 1'b1;
               state_q      <= S_OUT;
            end
            S_OUT: if (down_ready) begin
               if (idx_q == 2'd2) begin
                  idx_q        <= 2'd0;
                  err_q        <= 1'b0;
                  down_valid_q <= 1'b0;
                  down_last_q  <= 1'b0;
                  down_err_q   <= 1'b0;
                  up_ready_q   <= 1'b1;
                  state_q      <= S_LOAD;
               end else begin
                  idx_q       <= idx_q + 2'd1;
                  down_data_q <= buf_q[idx_q + 2'd1];
                  down_last_q <= (idx_q == 2'd1);
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign up_ready   = up_ready_q;
   assign down_valid = down_valid_q;
   assign down_data  = down_data_q;
   assign down_last  = down_last_q;
   assign down_err   = down_err_q;
endmodule
